// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame states and character-length helpers.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  localparam int MAX_DATA_W = 9;
  localparam int MIN_DATA_W = 5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Force a requested character length into 5..max_len.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    logic [3:0] res;
    if (len < 4'd5) begin
      res = 4'd5;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // XOR of the low 'len' bits; bits at or above len do not contribute.
  function automatic logic masked_xor(input logic [MAX_DATA_W-1:0] data, input logic [3:0] len);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (4'(i) < len) begin
        acc = acc ^ data[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO: rd_data always shows the oldest entry.
// The caller must not write when full or read when empty.
module uart_sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage array write; contents need no reset since level gates validity.
  always_ff @(posedge mclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO. Configuration is captured at each pop and
// held for the whole frame; queued characters are sent back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          mclk,
  input  logic                          reset,
  input  logic [BAUD_W-1:0]             baud_max_cnt,
  input  logic [3:0]                    data_len,
  input  logic [1:0]                    parity_sel,
  input  logic                          stop_sel,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  uart_state_t         state_r, state_n;
  logic [BAUD_W-1:0]   cnt_r, cnt_n, baud_r, baud_n;
  logic [3:0]          idx_r, idx_n, len_r, len_n;
  logic [DATA_W-1:0]   word_r, word_n, fifo_rd_data, data_sh;
  logic [1:0]          par_r, par_n;
  logic                stop_r, stop_n;
  logic                txd_r, txd_n, busy_r, done_r, done_n;
  logic                bit_end, par_on, pop, push, fifo_empty;
  logic [MAX_DATA_W-1:0] word_ext;
  logic [LW-1:0]       level;

  assign in_ready   = (level != FULL_LEVEL);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level == '0);
  assign fifo_level = level;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign done       = done_r;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .mclk    (mclk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (level)
  );

  // Next-state, bit sequencing, config capture and next serial-line value.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + BAUD_W'(1);
    idx_n   = idx_r;
    word_n  = word_r;
    len_n   = len_r;
    par_n   = par_r;
    stop_n  = stop_r;
    baud_n  = baud_r;
    pop     = 1'b0;
    done_n  = 1'b0;
    bit_end = (cnt_r == baud_r);
    par_on  = (par_r == PAR_ODD) || (par_r == PAR_EVEN);

    case (state_r)
      ST_IDLE: begin
        cnt_n = '0;
        idx_n = 4'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 4'd0;
          state_n = ST_DATA;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx_r == len_r - 4'd1) begin
            idx_n = 4'd0;
            if (par_on) begin
              state_n = ST_PARITY;
            end else begin
              state_n = ST_STOP;
            end
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = 4'd0;
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx_r == {3'b000, stop_r}) begin
            // Final stop bit: the next start bit may follow on this same edge.
            done_n = 1'b1;
            idx_n  = 4'd0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_n = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        idx_n   = 4'd0;
      end
    endcase

    if (pop) begin
      word_n = fifo_rd_data;
      len_n  = clamp_len(data_len, 4'(DATA_W));
      par_n  = parity_sel;
      stop_n = stop_sel;
      baud_n = baud_max_cnt;
    end else begin
      word_n = word_r;
    end

    word_ext = '0;
    word_ext[DATA_W-1:0] = word_n;
    data_sh = word_n >> idx_n;

    case (state_n)
      ST_START:  txd_n = 1'b0;
      ST_DATA:   txd_n = data_sh[0];
      ST_PARITY: txd_n = masked_xor(word_ext, len_n) ^ (par_n == PAR_ODD);
      default:   txd_n = 1'b1;
    endcase
  end

  // Frame state, captured configuration and registered line outputs.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 4'd0;
      word_r  <= '0;
      len_r   <= 4'd5;
      par_r   <= PAR_NONE;
      stop_r  <= 1'b0;
      baud_r  <= '0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      word_r  <= word_n;
      len_r   <= len_n;
      par_r   <= par_n;
      stop_r  <= stop_n;
      baud_r  <= baud_n;
      txd_r   <= txd_n;
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected frames (built from the
// framing rules) into a queue; a monitor decodes txd and compares frame by frame.
module tb_uart_tx_fifo;

  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int BAUD_W     = 16;

  logic              mclk = 1'b0;
  logic              reset = 1'b1;
  logic [BAUD_W-1:0] baud_max_cnt = '0;
  logic [3:0]        data_len = 4'd8;
  logic [1:0]        parity_sel = 2'b00;
  logic              stop_sel = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, txd, busy, done;
  logic [4:0]        fifo_level;

  always #5 mclk = ~mclk;

  uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)) dut (
    .mclk(mclk), .reset(reset), .baud_max_cnt(baud_max_cnt), .data_len(data_len),
    .parity_sel(parity_sel), .stop_sel(stop_sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .txd(txd), .busy(busy), .done(done), .fifo_level(fifo_level)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          baud;
    bit          b2b;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_pulses = 0;
  int   tag_cnt = 0;
  bit   in_frame = 1'b0;
  bit   pending_done = 1'b0;
  int   gap = 0;

  int cfg_len = 8, cfg_par = 0, cfg_baud = 4;
  bit cfg_stop = 1'b0;

  // Reference frame: start, len data bits LSB first, optional parity, 1 or 2 stops.
  function automatic exp_t make_frame(int d, bit b2b);
    exp_t e;
    int len, n, ones, b;
    len = (cfg_len < 5) ? 5 : ((cfg_len > DATA_W) ? DATA_W : cfg_len);
    e.bits = '1;
    e.bits[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < len; i++) begin
      b = (d >> i) & 1;
      ones += b;
      e.bits[n] = (b != 0);
      n++;
    end
    if (cfg_par == 1) begin
      e.bits[n] = ((ones % 2) == 0);
      n++;
    end else if (cfg_par == 2) begin
      e.bits[n] = ((ones % 2) == 1);
      n++;
    end
    n += cfg_stop ? 2 : 1;
    e.nbits = n;
    e.baud  = cfg_baud;
    e.b2b   = b2b;
    e.tag   = tag_cnt;
    tag_cnt++;
    return e;
  endfunction

  // Monitor: decode txd every cycle and compare against the expected-frame queue.
  initial begin : monitor
    exp_t cur;
    int   k;
    bit   ok;
    int   bad_k;
    logic bad_v;
    logic exp_bit;
    k = 0; ok = 1'b1; bad_k = 0; bad_v = 1'b0;
    forever begin
      @(negedge mclk);
      if (reset) begin
        in_frame = 1'b0;
        pending_done = 1'b0;
        gap = 0;
      end else begin
        if (done === 1'b1) done_pulses++;
        if (pending_done) begin
          tests++;
          if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse: done=%b required 1 after frame end", done);
          end
          pending_done = 1'b0;
        end else if (done !== 1'b0) begin
          tests++;
          fails++;
          $display("FAIL done_spurious: done=%b required 0", done);
        end
        if (!in_frame) begin
          if (txd === 1'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected_start: txd=0 required 1 (nothing queued)");
            end else begin
              cur = exp_q.pop_front();
              in_frame = 1'b1;
              k = 0;
              ok = 1'b1;
              if (cur.b2b && gap != 0) begin
                fails++;
                $display("FAIL b2b_gap: frame %0d idle gap %0d cycles required 0", cur.tag, gap);
              end
            end
          end else begin
            gap++;
          end
        end
        if (in_frame) begin
          exp_bit = cur.bits[k / (cur.baud + 1)];
          if (txd !== exp_bit && ok) begin
            ok = 1'b0;
            bad_k = k;
            bad_v = txd;
          end
          k++;
          if (k == cur.nbits * (cur.baud + 1)) begin
            tests++;
            if (!ok) begin
              fails++;
              $display("FAIL frame_%0d: cycle %0d txd=%b required %b", cur.tag, bad_k, bad_v,
                       cur.bits[bad_k / (cur.baud + 1)]);
            end
            in_frame = 1'b0;
            pending_done = 1'b1;
            gap = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_cfg(input int len, input int par, input bit stop2, input int baud);
    cfg_len = len; cfg_par = par; cfg_stop = stop2; cfg_baud = baud;
    data_len = 4'(len);
    parity_sel = 2'(par);
    stop_sel = stop2;
    baud_max_cnt = BAUD_W'(baud);
  endtask

  // Hold in_valid until the word is accepted on a rising edge; returns just after it.
  task automatic write_word(input int d, input bit b2b);
    int waited;
    bit acc;
    waited = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = DATA_W'(d);
    while (!acc && waited < 2000) begin
      if (in_ready === 1'b1) acc = 1'b1;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(make_frame(d, b2b));
    end else begin
      check("write_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || pending_done || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    if (n >= budget) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin : stimulus
    int d0;
    int nw;
    repeat (2) tick();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    repeat (2) tick();

    // 8N1, baud 4, 0x55, plus the write-to-start latency.
    set_cfg(8, 0, 1'b0, 4);
    write_word(9'h055, 1'b0);
    check("lat_level1", 32'(fifo_level), 32'd1);
    check("lat_txd_high", 32'(txd), 32'd1);
    tick();
    check("lat_txd_start", 32'(txd), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_level0", 32'(fifo_level), 32'd0);
    wait_idle(3000);

    // 8O2 then 8E2 with 0x55.
    set_cfg(8, 1, 1'b1, 4);
    write_word(9'h055, 1'b0);
    wait_idle(3000);
    set_cfg(8, 2, 1'b1, 4);
    write_word(9'h055, 1'b0);
    wait_idle(3000);

    // 5-bit character, even parity: upper bits ignored.
    set_cfg(5, 2, 1'b0, 4);
    write_word(9'h1F3, 1'b0);
    wait_idle(3000);

    // FIFO fill with back-to-back frames.
    set_cfg(8, 0, 1'b0, 2);
    d0 = done_pulses;
    for (int i = 0; i < 17; i++) write_word(int'($urandom_range(0, 511)), i > 0);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    wait_idle(5000);
    check("full_done_count", 32'(done_pulses - d0), 32'd17);

    // Configuration changes mid-frame do not affect the frame in flight.
    set_cfg(8, 2, 1'b1, 3);
    write_word(9'h0A7, 1'b0);
    repeat (6) tick();
    data_len = 4'd5; parity_sel = 2'b01; stop_sel = 1'b0; baud_max_cnt = BAUD_W'(0);
    wait_idle(3000);

    // Reset mid-frame with three words queued.
    set_cfg(8, 0, 1'b0, 4);
    for (int i = 0; i < 4; i++) write_word(int'($urandom_range(0, 511)), i > 0);
    check("rstmid_level", 32'(fifo_level), 32'd3);
    repeat (8) tick();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid_txd", 32'(txd), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_level0", 32'(fifo_level), 32'd0);
    check("rstmid_ready", 32'(in_ready), 32'd1);
    tick();
    check("rstmid_txd_edge", 32'(txd), 32'd1);
    reset = 1'b0;
    repeat (60) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_level", 32'(fifo_level), 32'd0);

    // Minimum baud, 8N1, 0xA5.
    set_cfg(8, 0, 1'b0, 0);
    write_word(9'h0A5, 1'b0);
    wait_idle(3000);

    // Randomized configurations and short bursts (out-of-range lengths included).
    for (int it = 0; it < 25; it++) begin
      set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) write_word(int'($urandom_range(0, 511)), w > 0);
      wait_idle(3000);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, run-time configurable character length, parity mode and stop-bit count. It succeeds the single-shot transmitter by decoupling the producer through a valid/ready write port and sending queued characters back-to-back without idle gaps. It sits between the loopback/control logic and the `txd` pin.

## Interface
- `DATA_W`, 9: maximum character width (5..9).
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `BAUD_W`, 16: width of `baud_max_cnt`.
- `mclk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `baud_max_cnt` in BAUD_W: bit period is `baud_max_cnt+1` mclk cycles.
- `data_len` in 4: character length 5..DATA_W; values outside this range are clamped to it.
- `parity_sel` in 2: 00 none, 01 odd, 10 even, 11 none.
- `stop_sel` in 1: 0 = one stop bit, 1 = two stop bits.
- `in_data` in DATA_W: character to queue, LSB-aligned.
- `in_valid` in 1: write request.
- `in_ready` out 1: FIFO not full.
- `txd` out 1: serial line; idles high.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at the end of each frame.
- `fifo_level` out clog2(FIFO_DEPTH)+1: number of occupied entries.

## Operation
- **Write.** A write happens on every edge where `in_valid && in_ready`. `in_ready = (fifo_level != FIFO_DEPTH)`. A full FIFO blocks writes even if a pop occurs on the same edge.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** `txd=1`. If the FIFO is non-empty: pop, latch the word plus `data_len`/`parity_sel`/`stop_sel`/`baud_max_cnt`, and go to START. The configuration is frozen for the whole frame.
- **START.** `txd=0` for one bit period, then go to DATA.
- **DATA.** Sends bits 0..len-1, LSB first, one per bit period. After the last bit, go to PARITY if parity is enabled, otherwise go to STOP.
- **PARITY.**
  - Odd: `txd = ~^data[len-1:0]`.
  - Even: `txd = ^data[len-1:0]`.
  - Bits above `len` are ignored.
- **STOP.** `txd=1` for 1 or 2 bit periods.
- **End of the final stop bit.**
  - `done` pulses.
  - If the FIFO is non-empty, pop and go directly to START, so the next start bit follows with no idle cycle.
  - Otherwise, go to IDLE.
- **Baud counter.** Counts 0..latched `baud_max_cnt`, clears at every state or bit change, and is held at 0 in IDLE. `baud_max_cnt=0` gives one-cycle bits.
- **Frame length.** (1 + len + P + S) × (`baud_max_cnt`+1) cycles, where P∈{0,1} is the parity bit and S∈{1,2} is the stop-bit count.
- **`busy`.** 1 in every state except IDLE.
- **Reset** (any time, including mid-frame):
  - FIFO emptied and state forced to IDLE.
  - `txd=1`, `busy=0`, `done=0`, `fifo_level=0`, `in_ready=1`.
  - A partially sent character is discarded.

## Timing
- A write on edge E into an empty FIFO while IDLE:
  - `fifo_level=1` after E.
  - Pop and START on E+1, so `txd` falls after edge E+1.
  - `fifo_level` returns to 0 after E+1.
- Each bit is exactly `baud_max_cnt+1` cycles. The `txd` transition is registered, with no glitches.
- `done` is high for exactly one cycle: the cycle after the edge that ends the last stop bit.
- Back-to-back frames: the next START begins on the same edge that raises `done`.
- Simultaneous write and pop: `fifo_level` stays unchanged.
- Changes to configuration inputs mid-frame have no effect until the next pop.

## Structure
- **Shared package `uart_pkg`:**
  - Parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
  - State encoding for IDLE/START/DATA/PARITY/STOP.
  - `clamp_len` function.
  - The same package is later used by the matching receiver.
- **Sub-module `uart_sync_fifo`:**
  - Parameters DATA_W and DEPTH; ports `mclk`, `reset`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `level`.
  - Read data is valid in the same cycle as `rd_en` (first-word fall-through).
- The top level holds the FSM, baud counter, bit index, and shift/parity registers.

## Test plan
- **8N1.** `baud_max_cnt=4`, `data_len=8`, `parity_sel=00`, `stop_sel=0`; write 0x55.
  - `txd` is 0,1,0,1,0,1,0,1,0,1 for 5 cycles per bit, then high.
  - `done` pulses once; frame = 50 cycles.
- **Odd parity, two stop bits.** 8O2, write 0x55 (four ones).
  - Parity bit = 1, followed by two stop periods; frame = 12 bit periods.
  - Repeat with even parity: parity bit = 0.
- **5-bit character.** `data_len=5`, write 0x1F3.
  - Only 1,1,0,0,1 are sent (LSB first).
  - Even parity bit = 1; frame = 1+5+1+1 bits.
- **FIFO full and back-to-back.** With `baud_max_cnt=2`, write 17 words with `in_valid` held high.
  - `in_ready` drops when `fifo_level=16`.
  - All 17 characters are sent in order, with no high cycles between a stop bit and the next start bit.
  - `done` pulses 17 times.
- **Reset mid-frame.** Assert `reset` during the DATA state with 3 words queued.
  - Next edge: `txd=1`, `busy=0`, `fifo_level=0`.
  - After release, nothing is sent until a new write.
- **Minimum baud.** `baud_max_cnt=0`, 8N1, write 0xA5.
  - One-cycle bits 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses 10 cycles after the start bit begins.
